load_store_unit: RTL and testbench
==================================

# load_store_unit

Requester-side front end for the single-port word-addressed data memory. It takes byte-addressed load/store requests from the execute stage and drives the memory's `A`/`WE`/`WD` inputs. It consumes the memory's one-cycle registered `RD`, performing lane selection, sign/zero extension and read-modify-write for byte/halfword stores. It sits between the core pipeline and the data memory, and is the only master of that memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 10 — byte-address width; memory word address is `ADDR_WIDTH-2` bits.
- `DATA_WIDTH`, 32 — word width; only 32 is supported.

Ports:
- `CLK` in 1 — clock; all state updates on rising edge.
- `RST_N` in 1 — one clock; reset is synchronous and active-low.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — unit can accept; a transfer occurs when `req_valid & req_ready` at a rising edge.
- `req_we` in 1 — 1 = store, 0 = load.
- `req_funct3` in 3 — loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in `ADDR_WIDTH` — byte address.
- `req_wdata` in 32 — store data, right-aligned.
- `resp_valid` out 1 — one-cycle completion pulse; no back-pressure.
- `resp_rdata` out 32 — load result; 0 for stores and errors.
- `resp_misaligned` out 1 — request rejected; meaningful only with `resp_valid`.
- `mem_A` out `ADDR_WIDTH-2` — memory word address (`addr[ADDR_WIDTH-1:2]`).
- `mem_WE` out 1 — memory write enable.
- `mem_WD` out 32 — memory write data.
- `mem_RD` in 32 — memory read data, valid the cycle after a `mem_WE=0` edge.

## Operation
- FSM states: IDLE, LOAD_WAIT, RMW_MERGE.
- `req_ready` is 1 only in IDLE with `RST_N` high.
- **Memory outputs are combinational.**
  - IDLE: driven from the request on an accepted, legal transfer; otherwise `mem_WE=0`.
  - LOAD_WAIT and RMW_MERGE: driven from the captured request registers.
- **Illegal requests:** funct3 011/110/111; store funct3 ≥100; LH/LHU/SH with `addr[0]=1`; LW/SW with `addr[1:0]≠0`.
  - No memory write is performed.
  - Next cycle: `resp_valid=1`, `resp_misaligned=1`, `resp_rdata=0`. Stay in IDLE.
- **SW:** accept cycle drives `mem_WE=1`, `mem_WD=req_wdata`. Next cycle: `resp_valid=1`. Stay in IDLE.
- **Loads:**
  - Accept cycle drives `mem_WE=0`, `mem_A`. Capture `funct3` and `addr[1:0]`. Go to LOAD_WAIT.
  - LOAD_WAIT: extract from `mem_RD` and register into `resp_rdata`. Go to IDLE; `resp_valid=1` the following cycle.
- **SB/SH:**
  - Accept cycle issues a read. Capture address, `funct3` and `wdata`. Go to RMW_MERGE.
  - RMW_MERGE: `mem_WE=1`, `mem_WD` = `mem_RD` with the selected lane replaced (SB: `wdata[7:0]`; SH: `wdata[15:0]`). Go to IDLE; `resp_valid=1` the following cycle.
- **Lane extraction (little-endian):** byte k = `RD[8k+7:8k]`, k = `addr[1:0]`; half h = `RD[16h+15:16h]`, h = `addr[1]`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- `resp_valid`, `resp_rdata` and `resp_misaligned` are registered.
  - A response for request N may coincide with acceptance of request N+1.
  - All three return to 0 the cycle after any pulse.

## Timing
- **Reset (`RST_N` low at an edge):**
  - State → IDLE; `resp_valid=0`, `resp_rdata=0`, `resp_misaligned=0`.
  - While `RST_N` is low: `mem_WE=0` and `req_ready=0`.
- **Reset mid-operation:**
  - LOAD_WAIT: the response is dropped.
  - RMW_MERGE: the write is suppressed and the memory word is unchanged.
- **Latency (accept edge T → `resp_valid` high):**
  - SW / illegal: cycle T+1.
  - Load / SB / SH: cycle T+2.
- **Throughput:** SW and illegal requests 1/cycle; loads and SB/SH 1 per 2 cycles.
- In SB/SH, `mem_WE` is high for exactly one cycle (the RMW_MERGE cycle).
- No request is accepted in LOAD_WAIT or RMW_MERGE. `req_*` inputs are ignored there; captured copies are used.

## Test plan
- SW addr 0x010 data 0xDEADBEEF, then LW 0x010 → SW `resp_valid` at T+1. LW `resp_rdata=0xDEADBEEF`, `resp_misaligned=0` at T+2.
- With word 0xDEADBEEF at 0x010:
  - LB 0x011 → 0xFFFFFFBE; LBU 0x011 → 0x000000BE.
  - LH 0x012 → 0xFFFFDEAD; LHU 0x012 → 0x0000DEAD.
- SB 0x013 data 0x12, then SH 0x010 data 0x5678, then LW 0x010 → 0x12AD5678. `mem_WE` is high exactly one cycle per store; `req_ready` is low during RMW_MERGE.
- LW 0x011, then SH 0x013, then funct3 011 → each gives `resp_misaligned=1`, `rdata=0` at T+1. `mem_WE` is never asserted; memory is unchanged.
- Three back-to-back SWs (0x000, 0x004, 0x008) with `req_valid` held → all accepted on consecutive edges, three consecutive `resp_valid` pulses.
- SB 0x010 with `RST_N` driven low during RMW_MERGE → `mem_WE=0`, no `resp_valid`, all outputs 0. A subsequent LW 0x010 returns the prior word.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the request/response handshake between the execute stage and the
// load/store unit, together with the unit's port to the single-port data memory.
//   slave  : the load_store_unit side (accepts requests, masters the memory)
//   master : the pipeline + memory side (issues requests, returns mem_RD)
// Signals:
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata - request channel
//   resp_valid/resp_rdata/resp_misaligned                     - response channel
//   mem_A/mem_WE/mem_WD/mem_RD                                - data memory port
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_misaligned;

  logic [ADDR_WIDTH-3:0] mem_A;
  logic                  mem_WE;
  logic [DATA_WIDTH-1:0] mem_WD;
  logic [DATA_WIDTH-1:0] mem_RD;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    output req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_A, mem_WE, mem_WD
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_RD,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned,
           mem_A, mem_WE, mem_WD
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Requester-side front end of the word-addressed data memory. Accepts byte
// addressed loads/stores, extracts and extends load lanes from the registered
// memory read data, and performs read-modify-write for byte/halfword stores.
// Ports:
//   CLK   - clock, rising edge
//   RST_N - synchronous active-low reset
//   bus   - load_store_unit_if.slave: request/response channel and memory port
module load_store_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic              CLK,
  input  logic              RST_N,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_MERGE} state_t;

  state_t                state;
  state_t                state_next;

  logic                  ready;
  logic                  accept;
  logic                  illegal;
  logic                  is_sw;

  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [2:0]            cap_funct3;
  logic [15:0]           cap_wdata;

  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] extracted;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;

  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_mis_q;

  // Request decode: legality and whether a store can complete in one cycle.
  always_comb begin
    ready   = (state == IDLE) && RST_N;
    accept  = bus.req_valid && ready;
    illegal = 1'b0;
    case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      default: ;
    endcase
    if (bus.req_we && bus.req_funct3[2])
      illegal = 1'b1;
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
      illegal = 1'b1;
    if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
      illegal = 1'b1;
    is_sw = !illegal && bus.req_we && (bus.req_funct3 == 3'b010);
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next-state logic: loads and sub-word stores need a second cycle to see mem_RD.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !illegal) begin
          if (!bus.req_we)
            state_next = LOAD_WAIT;
          else if (!is_sw)
            state_next = RMW_MERGE;
        end
      end
      LOAD_WAIT: state_next = IDLE;
      RMW_MERGE: state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Lane replacement for SB/SH on top of the word read at accept time.
  always_comb begin
    merged = bus.mem_RD;
    if (cap_funct3[0])
      merged[{cap_addr[1], 4'b0000} +: 16] = cap_wdata;
    else
      merged[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
  end

  // Little-endian lane extraction with sign/zero extension for loads.
  always_comb begin
    byte_sel = bus.mem_RD[{cap_addr[1:0], 3'b000} +: 8];
    half_sel = bus.mem_RD[{cap_addr[1], 4'b0000} +: 16];
    case (cap_funct3)
      3'b000:  extracted = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  extracted = {{16{half_sel[15]}}, half_sel};
      3'b010:  extracted = bus.mem_RD;
      3'b100:  extracted = {24'h000000, byte_sel};
      3'b101:  extracted = {16'h0000, half_sel};
      default: extracted = '0;
    endcase
  end

  // Output logic: memory port is combinational; the merge write is gated by
  // RST_N so a reset landing in RMW_MERGE leaves the memory word untouched.
  always_comb begin
    bus.req_ready = ready;
    bus.mem_A     = bus.req_addr[ADDR_WIDTH-1:2];
    bus.mem_WE    = 1'b0;
    bus.mem_WD    = bus.req_wdata;
    case (state)
      IDLE: begin
        bus.mem_WE = accept && is_sw;
      end
      LOAD_WAIT: begin
        bus.mem_A = cap_addr[ADDR_WIDTH-1:2];
      end
      RMW_MERGE: begin
        bus.mem_A  = cap_addr[ADDR_WIDTH-1:2];
        bus.mem_WE = RST_N;
        bus.mem_WD = merged;
      end
      default: ;
    endcase
  end

  // Capture the request so req_* may change while the unit is busy.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cap_addr   <= '0;
      cap_funct3 <= '0;
      cap_wdata  <= '0;
    end else if (accept) begin
      cap_addr   <= bus.req_addr;
      cap_funct3 <= bus.req_funct3;
      cap_wdata  <= bus.req_wdata[15:0];
    end
  end

  // Registered response: every pulse lasts one cycle and clears afterwards.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_mis_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && illegal) begin
            resp_valid_q <= 1'b1;
            resp_mis_q   <= 1'b1;
          end else if (accept && is_sw) begin
            resp_valid_q <= 1'b1;
          end
        end
        LOAD_WAIT: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= extracted;
        end
        RMW_MERGE: begin
          resp_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_rdata      = resp_rdata_q;
  assign bus.resp_misaligned = resp_mis_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: a table of directed requests with
// hand-computed results, plus back-to-back stores and a reset during RMW_MERGE.
// A small registered-read memory model sits on the memory port.
module tb_load_store_unit;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;

  int compared   = 0;
  int mismatched = 0;

  load_store_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-port memory: write when WE, otherwise registered read.
  logic [31:0] tb_mem [0:255];
  always @(posedge clk) begin
    if (bus.mem_WE)
      tb_mem[bus.mem_A] <= bus.mem_WD;
    else
      bus.mem_RD <= tb_mem[bus.mem_A];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  vec_t vecs [21];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                                input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  // Issue one request, wait (bounded) for its response and check it.
  task automatic run_vector(input vec_t v, input string tag);
    int   lat;
    int   we_cnt;
    bit   got;
    logic [31:0] rdata;
    logic mis;
    @(negedge clk);
    apply_stimulus(v.we, v.f3, v.addr, v.wdata);
    #1;
    check_output({tag, " ready"}, {31'd0, bus.req_ready}, 32'd1);
    we_cnt = int'(bus.mem_WE);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    rdata = '0;
    mis = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      #1;
      lat++;
      we_cnt += int'(bus.mem_WE);
      if (i == 0 && v.exp_lat == 2)
        check_output({tag, " busy ready"}, {31'd0, bus.req_ready}, 32'd0);
      if (bus.resp_valid) begin
        got   = 1'b1;
        rdata = bus.resp_rdata;
        mis   = bus.resp_misaligned;
      end
    end
    check_output({tag, " resp seen"}, {31'd0, got}, 32'd1);
    check_output({tag, " latency"}, lat, v.exp_lat);
    check_output({tag, " rdata"}, rdata, v.exp_rdata);
    check_output({tag, " misaligned"}, {31'd0, mis}, {31'd0, v.exp_mis});
    check_output({tag, " mem_WE cycles"}, we_cnt, v.exp_we);
    @(negedge clk);
    check_output({tag, " pulse end"}, {bus.resp_valid, bus.resp_misaligned, bus.resp_rdata[29:0]}, 32'd0);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [9:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic em,
                              input int el, input int ew);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_mis = em; v.exp_lat = el; v.exp_we = ew;
    return v;
  endfunction

  initial begin
    // Directed sequence; later entries depend on memory contents from earlier ones.
    vecs[0]  = mk(1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h0,        0, 1, 1); // SW
    vecs[1]  = mk(0, 3'b010, 10'h010, 32'h0,        32'hDEADBEEF, 0, 2, 0); // LW
    vecs[2]  = mk(0, 3'b000, 10'h011, 32'h0,        32'hFFFFFFBE, 0, 2, 0); // LB
    vecs[3]  = mk(0, 3'b100, 10'h011, 32'h0,        32'h000000BE, 0, 2, 0); // LBU
    vecs[4]  = mk(0, 3'b001, 10'h012, 32'h0,        32'hFFFFDEAD, 0, 2, 0); // LH
    vecs[5]  = mk(0, 3'b101, 10'h012, 32'h0,        32'h0000DEAD, 0, 2, 0); // LHU
    vecs[6]  = mk(1, 3'b000, 10'h013, 32'h00000012, 32'h0,        0, 2, 1); // SB
    vecs[7]  = mk(1, 3'b001, 10'h010, 32'h00005678, 32'h0,        0, 2, 1); // SH
    vecs[8]  = mk(0, 3'b010, 10'h010, 32'h0,        32'h12AD5678, 0, 2, 0); // LW
    vecs[9]  = mk(0, 3'b010, 10'h011, 32'h0,        32'h0,        1, 1, 0); // LW misaligned
    vecs[10] = mk(1, 3'b001, 10'h013, 32'hFFFF0000, 32'h0,        1, 1, 0); // SH misaligned
    vecs[11] = mk(0, 3'b011, 10'h010, 32'h0,        32'h0,        1, 1, 0); // funct3 011
    vecs[12] = mk(1, 3'b100, 10'h010, 32'hFFFFFFFF, 32'h0,        1, 1, 0); // store funct3 100
    vecs[13] = mk(0, 3'b010, 10'h010, 32'h0,        32'h12AD5678, 0, 2, 0); // LW unchanged
    vecs[14] = mk(0, 3'b000, 10'h013, 32'h0,        32'h00000012, 0, 2, 0); // LB positive
    vecs[15] = mk(0, 3'b001, 10'h010, 32'h0,        32'h00005678, 0, 2, 0); // LH positive
    vecs[16] = mk(0, 3'b000, 10'h012, 32'h0,        32'hFFFFFFAD, 0, 2, 0); // LB lane 2
    vecs[17] = mk(1, 3'b001, 10'h012, 32'h1234ABCD, 32'h0,        0, 2, 1); // SH upper half
    vecs[18] = mk(1, 3'b000, 10'h011, 32'hFFFFFF99, 32'h0,        0, 2, 1); // SB lane 1
    vecs[19] = mk(0, 3'b010, 10'h010, 32'h0,        32'hABCD9978, 0, 2, 0); // LW merged
    vecs[20] = mk(0, 3'b101, 10'h012, 32'h0,        32'h0000ABCD, 0, 2, 0); // LHU upper

    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_funct3 = 3'b010;
    #1;
    check_output("reset resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check_output("reset resp_rdata", bus.resp_rdata, 32'd0);
    check_output("reset misaligned", {31'd0, bus.resp_misaligned}, 32'd0);
    check_output("reset req_ready", {31'd0, bus.req_ready}, 32'd0);
    check_output("reset mem_WE", {31'd0, bus.mem_WE}, 32'd0);
    bus.req_valid = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++)
      run_vector(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back SWs accepted on consecutive edges.
    @(negedge clk);
    apply_stimulus(1, 3'b010, 10'h000, 32'h11111111);
    #1;
    check_output("b2b ready0", {31'd0, bus.req_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check_output($sformatf("b2b pulse%0d", k), {31'd0, bus.resp_valid}, 32'd1);
      if (k < 2) begin
        bus.req_addr  = 10'(4 * (k + 1));
        bus.req_wdata = (k == 0) ? 32'h22222222 : 32'h33333333;
        #1;
        check_output($sformatf("b2b ready%0d", k + 1), {31'd0, bus.req_ready}, 32'd1);
      end else begin
        bus.req_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_output("b2b pulse end", {31'd0, bus.resp_valid}, 32'd0);
    run_vector(mk(0, 3'b010, 10'h000, 32'h0, 32'h11111111, 0, 2, 0), "b2b LW0");
    run_vector(mk(0, 3'b010, 10'h004, 32'h0, 32'h22222222, 0, 2, 0), "b2b LW4");
    run_vector(mk(0, 3'b010, 10'h008, 32'h0, 32'h33333333, 0, 2, 0), "b2b LW8");

    // Reset asserted during RMW_MERGE: write suppressed, response dropped.
    @(negedge clk);
    apply_stimulus(1, 3'b000, 10'h010, 32'h00000055);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_output("rmw rst mem_WE", {31'd0, bus.mem_WE}, 32'd0);
    check_output("rmw rst req_ready", {31'd0, bus.req_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_output("rmw rst resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check_output("rmw rst resp_rdata", bus.resp_rdata, 32'd0);
    check_output("rmw rst misaligned", {31'd0, bus.resp_misaligned}, 32'd0);
    check_output("rmw rst mem_WE after", {31'd0, bus.mem_WE}, 32'd0);
    rst_n = 1'b1;
    check_output("rmw rst mem word", tb_mem[4], 32'hABCD9978);
    run_vector(mk(0, 3'b010, 10'h010, 32'h0, 32'hABCD9978, 0, 2, 0), "post rst LW");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
